// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator measurement scheduler.
// CHECKSUM_EN adds one XOR checksum byte to every frame.
package ro_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] HDR_MARK = 4'hA;

    function automatic int frame_bytes(input int cnt_w);
`ifdef CHECKSUM_EN
        return 2 + cnt_w / 8;
`else
        return 1 + cnt_w / 8;
`endif
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_byte_ser.sv
// Loads a {header, count} frame and emits it MSB-first over valid/ready.
// CHECKSUM_EN appends the XOR of all previous frame bytes.
module ro_byte_ser
    import ro_meas_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [7:0]       i_hdr,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_tx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_last_acc
);

    localparam int NB = frame_bytes(CNT_W);

    logic [CNT_W-1:0] r_shift;
    logic [2:0]       r_rem;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             w_xfer;
    logic [7:0]       w_next;

    assign w_xfer     = r_valid & i_tx_ready;
    assign o_last_acc = w_xfer & (r_rem == 3'd0);
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

`ifdef CHECKSUM_EN
    logic [7:0] r_csum;

    assign w_next = (r_rem == 3'd1) ? r_csum : r_shift[CNT_W-1 -: 8];

    // Running XOR of every byte placed on tx_data in this frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= 8'd0;
        end else if (i_load) begin
            r_csum <= i_hdr;
        end else if (w_xfer && r_rem != 3'd0) begin
            r_csum <= r_csum ^ w_next;
        end
    end
`else
    assign w_next = r_shift[CNT_W-1 -: 8];
`endif

    // r_rem counts bytes still to follow the one currently presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_rem   <= 3'd0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_cnt;
            r_rem   <= 3'(NB - 1);
            r_data  <= i_hdr;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (r_rem == 3'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_data  <= w_next;
                r_shift <= r_shift << 6'd8;
                r_rem   <= r_rem - 3'd1;
            end
        end
    end

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator scan: settle, measure window, then send a framed count per oscillator.
// CHECKSUM_EN (optional) adds an XOR checksum byte to each frame.
module ro_meas_sched
    import ro_meas_pkg::*;
#(
    parameter int NUM_RO     = 4,
    parameter int CNT_W      = 32,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_RO-1:0] ro_mask,
    output logic [NUM_RO-1:0] ro_en,
    output logic              cnt_clr,
    input  logic [CNT_W-1:0]  cnt_val,
    output logic              win_en,
    input  logic              win_done,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);

    state_t            r_state;
    logic [NUM_RO-1:0] r_mask;
    logic [3:0]        r_idx;
    logic [15:0]       r_settle;
    logic [NUM_RO-1:0] r_ro_en;
    logic              r_cnt_clr;
    logic              r_win_en;
    logic              r_busy;
    logic              r_frame_done;

    logic [15:0]       w_mask_in;
    logic [15:0]       w_mask_rem;
    logic              w_load;
    logic              w_last_acc;

    function automatic logic [NUM_RO-1:0] onehot(input logic [3:0] i);
        logic [15:0] v;
        v = 16'd1 << i;
        return v[NUM_RO-1:0];
    endfunction

    assign w_mask_in  = 16'(ro_mask);
    assign w_mask_rem = 16'(r_mask) & ~(16'd1 << r_idx);
    assign w_load     = (r_state == ST_MEASURE) && win_done;

    assign ro_en      = r_ro_en;
    assign cnt_clr    = r_cnt_clr;
    assign win_en     = r_win_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    ro_byte_ser #(.CNT_W(CNT_W)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_hdr      ({HDR_MARK, r_idx}),
        .i_cnt      (cnt_val),
        .i_tx_ready (tx_ready),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .o_last_acc (w_last_acc)
    );

    // Scan FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_idx        <= 4'd0;
            r_settle     <= 16'd0;
            r_ro_en      <= '0;
            r_cnt_clr    <= 1'b1;
            r_win_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_mask <= ro_mask;
                        if (w_mask_in != 16'd0) begin
                            r_idx    <= lowest_bit(w_mask_in);
                            r_ro_en  <= onehot(lowest_bit(w_mask_in));
                            r_settle <= 16'd0;
                            r_state  <= ST_SETTLE;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == 16'(SETTLE_CYC - 1)) begin
                        r_win_en  <= 1'b1;
                        r_cnt_clr <= 1'b0;
                        r_state   <= ST_MEASURE;
                    end else begin
                        r_settle <= r_settle + 16'd1;
                    end
                end
                ST_MEASURE: begin
                    if (win_done) begin
                        r_win_en  <= 1'b0;
                        r_ro_en   <= '0;
                        r_cnt_clr <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_last_acc) r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    r_mask <= w_mask_rem[NUM_RO-1:0];
                    if (w_mask_rem != 16'd0) begin
                        r_idx    <= lowest_bit(w_mask_rem);
                        r_ro_en  <= onehot(lowest_bit(w_mask_rem));
                        r_settle <= 16'd0;
                        r_state  <= ST_SETTLE;
                    end else begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ro_meas_sched.md
# ro_meas_sched

Measurement scheduler for the ring-oscillator array. It selects one oscillator at a time from a latched mask and gates it on. It then drives the measurement window and captures the edge count at window end. Finally it serializes a framed result to the UART transmitter over a valid/ready byte handshake. It sits between the host start trigger, the window/counter datapath and the UART TX.

## Interface
- NUM_RO, 4, number of oscillators; 1..16.
- CNT_W, 32, count width; multiple of 8, 8..32.
- SETTLE_CYC, 16, cycles each oscillator runs with the counter held clear before the window opens; ≥1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  scan request; sampled in IDLE only.
- ro_mask  in  NUM_RO  oscillators to include; latched on accepted start.
- ro_en  out  NUM_RO  one-hot oscillator enable.
- cnt_clr  out  1  holds the external edge counter at zero.
- cnt_val  in  CNT_W  external edge count.
- win_en  out  1  window block enable.
- win_done  in  1  one-cycle window-end pulse.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at scan end.

## Operation
- States:
  - IDLE: on start=1, latch mask, set idx to the lowest set bit, go to SETTLE. If mask is 0, go to DONE.
  - SETTLE: ro_en[idx]=1, cnt_clr=1; after SETTLE_CYC cycles go to MEASURE.
  - MEASURE: ro_en[idx]=1, win_en=1, cnt_clr=0; on win_done=1 latch cnt_val, go to SEND.
  - SEND: ro_en=0, win_en=0, cnt_clr=1. Emit the header 0xA0|idx[3:0], then CNT_W/8 count bytes MSB-first. After the last accepted byte go to NEXT.
  - NEXT: clear idx from the latched mask. If bits remain, set idx to the next lowest, go to SETTLE; else go to DONE.
  - DONE: pulse frame_done, go to IDLE.
- A byte transfers on a cycle with tx_valid & tx_ready.
- tx_data is held stable while tx_valid=1 & tx_ready=0.
- tx_valid never drops without a transfer.
- start while busy is ignored. ro_mask changes after the latch are ignored.
- win_done outside MEASURE is ignored.
- At most one ro_en bit is high at any time.

## Timing
- Reset values: ro_en=0, win_en=0, cnt_clr=1, tx_valid=0, tx_data=0, busy=0, frame_done=0, state IDLE.
- rst_n low mid-scan: all outputs take reset values at that edge; the partial frame is abandoned, no further bytes are emitted.
- start sampled at edge k: busy=1 and ro_en one-hot from k+1.
- SETTLE lasts exactly SETTLE_CYC cycles; win_en rises the next cycle.
- win_done sampled at edge m: cnt_val captured at m. From m+1, win_en=0, ro_en=0, and tx_valid=1 with the header.
- Zero stall: header plus CNT_W/8 bytes take 1+CNT_W/8 cycles.
- frame_done rises one cycle after the last NEXT. busy falls together with frame_done.
- Empty mask: frame_done at k+1, no bytes.

## Configuration
- CHECKSUM_EN defined: each frame gets one extra byte after the count, the XOR of the header and all count bytes.
- CHECKSUM_EN undefined: no checksum byte; the frame is header plus count only.

## Structure
- Package ro_meas_pkg holds:
  - state enum (IDLE, SETTLE, MEASURE, SEND, NEXT, DONE)
  - HDR_MARK = 4'hA
  - function for frame length in bytes
- Sub-module ro_byte_ser:
  - loads a {header, count} word and emits its bytes MSB-first over valid/ready.
  - asserts last_acc on the final accepted byte.
  - computes the checksum byte when CHECKSUM_EN is defined.

## Test plan
- NUM_RO=4, mask=4'b0101, tx_ready=1, counts 0x00001234 and 0x0000ABCD. Required:
  - ro_en sequence is 0001 then 0100.
  - bytes A0 00 00 12 34, then A2 00 00 AB CD.
  - one frame_done pulse.
- mask=0 start -> frame_done at k+1, tx_valid never high, busy high for one cycle.
- tx_ready toggles 1-0-0-1 during SEND -> tx_data stable across stalls, no byte lost or duplicated.
- start re-pulsed during MEASURE, win_done pulsed during SETTLE -> both ignored; exactly one frame per selected oscillator.
- rst_n=0 mid-count-byte -> next edge all outputs at reset values; a fresh start after release gives a complete frame.
- CHECKSUM_EN, idx=1, count 0x01020304 -> bytes A1 01 02 03 04 A5.
